ddr_wr_arbiter: RTL and testbench



---
 rtl/ddr_wr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ddr_wr_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_arbiter.sv
// Round-robin arbiter sharing the DDR controller's single write command/data port
// among CH_NUM line-write buffers; controller strobes are routed back to the granted channel.
module ddr_wr_arbiter #(
  parameter int CH_NUM      = 4,
  parameter int ADDR_WIDTH  = 27,
  parameter int LEN_WIDTH   = 16,
  parameter int DQ_WIDTH    = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                             ddr_clk,
  input  logic                             ddr_rst,
  input  logic [CH_NUM-1:0]                ch_en,
  input  logic [CH_NUM-1:0]                ch_wreq,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]     ch_waddr,
  input  logic [CH_NUM*LEN_WIDTH-1:0]      ch_wr_len,
  input  logic [CH_NUM*8*DQ_WIDTH-1:0]     ch_wdata,
  output logic [CH_NUM-1:0]                ch_wrdy,
  output logic [CH_NUM-1:0]                ch_wdata_req,
  output logic [CH_NUM-1:0]                ch_wdone,
  output logic                             ddr_wreq,
  output logic [ADDR_WIDTH-1:0]            ddr_waddr,
  output logic [LEN_WIDTH-1:0]             ddr_wr_len,
  input  logic                             ddr_wrdy,
  input  logic                             ddr_wdata_req,
  input  logic                             ddr_wdone,
  output logic [8*DQ_WIDTH-1:0]            ddr_wdata,
  output logic [1:0]                       grant_id,
  output logic                             busy,
  output logic                             err_overrun,
  output logic                             err_timeout
);

  localparam int DW   = 8*DQ_WIDTH;
  localparam int WD_W = $clog2(TIMEOUT_CYC+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_rr_ptr;
  logic [1:0]            r_grant_id;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [LEN_WIDTH-1:0]  r_wr_len;
  logic [LEN_WIDTH:0]    r_beat_cnt;
  logic [WD_W-1:0]       r_wd;
  logic                  r_err_overrun;
  logic                  r_err_timeout;

  logic [3:0]            w_elig;
  logic [ADDR_WIDTH-1:0] w_addr_arr [4];
  logic [LEN_WIDTH-1:0]  w_len_arr  [4];
  logic [DW-1:0]         w_data_arr [4];
  logic                  w_found;
  logic [1:0]            w_pick;
  logic [1:0]            w_rr_next;
  logic                  w_end;
  logic                  w_timeout;

  // Wraps a sum of two channel indices (each < CH_NUM) back into range.
  function automatic logic [1:0] f_wrap(input logic [2:0] v);
    logic [2:0] t;
    t = (v >= 3'(CH_NUM)) ? (v - 3'(CH_NUM)) : v;
    return t[1:0];
  endfunction

  // Unused slots are tied off so a 2-bit index never reaches past the array.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    if (gi < CH_NUM) begin : g_used
      assign w_elig[gi]     = ch_wreq[gi] & ch_en[gi];
      assign w_addr_arr[gi] = ch_waddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_len_arr[gi]  = ch_wr_len[gi*LEN_WIDTH +: LEN_WIDTH];
      assign w_data_arr[gi] = ch_wdata[gi*DW +: DW];
    end else begin : g_unused
      assign w_elig[gi]     = 1'b0;
      assign w_addr_arr[gi] = '0;
      assign w_len_arr[gi]  = '0;
      assign w_data_arr[gi] = '0;
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = 0; k < CH_NUM; k++) begin
      if (!w_found && w_elig[f_wrap({1'b0, r_rr_ptr} + 3'(k))]) begin
        w_found = 1'b1;
        w_pick  = f_wrap({1'b0, r_rr_ptr} + 3'(k));
      end
    end
  end

  assign w_rr_next = f_wrap({1'b0, r_grant_id} + 3'd1);

  always_comb begin
    w_state_next = r_state;
    w_end        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_next = S_REQ;
      end
      S_REQ: begin
        if (ddr_wrdy) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (ddr_wdone) begin
          w_end        = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_wd >= WD_W'(TIMEOUT_CYC-1)) begin
          w_end        = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_waddr       <= '0;
      r_wr_len      <= '0;
      r_beat_cnt    <= '0;
      r_wd          <= '0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_found) begin
        r_grant_id <= w_pick;
        r_waddr    <= w_addr_arr[w_pick];
        r_wr_len   <= w_len_arr[w_pick];
      end
      // Counters are cleared while waiting in REQ so DATA always starts from zero.
      if (r_state == S_REQ) begin
        r_beat_cnt <= '0;
        r_wd       <= '0;
      end else if (r_state == S_DATA) begin
        if (ddr_wdata_req) begin
          if (r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + 1'b1;
          if (r_beat_cnt >= {1'b0, r_wr_len}) r_err_overrun <= 1'b1;
        end
        if (r_wd != WD_W'(TIMEOUT_CYC)) r_wd <= r_wd + 1'b1;
        if (w_end) r_rr_ptr <= w_rr_next;
        if (w_timeout) r_err_timeout <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_route
    assign ch_wrdy[gi]      = ddr_wrdy      & (r_state == S_REQ)  & (r_grant_id == 2'(gi));
    assign ch_wdata_req[gi] = ddr_wdata_req & (r_state == S_DATA) & (r_grant_id == 2'(gi));
    assign ch_wdone[gi]     = ddr_wdone     & (r_state == S_DATA) & (r_grant_id == 2'(gi));
  end

  // Unregistered so a channel's bypassed first beat reaches the controller with no delay.
  assign ddr_wdata   = w_data_arr[r_grant_id];
  assign ddr_wreq    = (r_state == S_REQ);
  assign ddr_waddr   = r_waddr;
  assign ddr_wr_len  = r_wr_len;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state != S_IDLE);
  assign err_overrun = r_err_overrun;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Directed-plus-random bench for ddr_wr_arbiter; the bench plays the DDR controller and
// predicts grants and error flags from a simple round-robin reference model.
module tb_ddr_wr_arbiter;

  localparam int CH = 4;
  localparam int AW = 27;
  localparam int LW = 16;
  localparam int DQ = 16;
  localparam int DW = 8*DQ;
  localparam int TO = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [CH-1:0]  ch_en, ch_wreq;
  logic [AW-1:0]  addr [CH];
  logic [LW-1:0]  len  [CH];
  logic [DW-1:0]  data [CH];
  logic [CH*AW-1:0] ch_waddr_f;
  logic [CH*LW-1:0] ch_wr_len_f;
  logic [CH*DW-1:0] ch_wdata_f;
  logic [CH-1:0]  ch_wrdy, ch_wdata_req, ch_wdone;
  logic           ddr_wreq, ddr_wrdy, ddr_wdata_req, ddr_wdone;
  logic [AW-1:0]  ddr_waddr;
  logic [LW-1:0]  ddr_wr_len;
  logic [DW-1:0]  ddr_wdata;
  logic [1:0]     grant_id;
  logic           busy, err_overrun, err_timeout;

  for (genvar gi = 0; gi < CH; gi++) begin : g_pack
    assign ch_waddr_f[gi*AW +: AW]  = addr[gi];
    assign ch_wr_len_f[gi*LW +: LW] = len[gi];
    assign ch_wdata_f[gi*DW +: DW]  = data[gi];
  end

  ddr_wr_arbiter #(
    .CH_NUM(CH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DQ_WIDTH(DQ), .TIMEOUT_CYC(TO)
  ) dut (
    .ddr_clk(clk), .ddr_rst(rst), .ch_en(ch_en), .ch_wreq(ch_wreq),
    .ch_waddr(ch_waddr_f), .ch_wr_len(ch_wr_len_f), .ch_wdata(ch_wdata_f),
    .ch_wrdy(ch_wrdy), .ch_wdata_req(ch_wdata_req), .ch_wdone(ch_wdone),
    .ddr_wreq(ddr_wreq), .ddr_waddr(ddr_waddr), .ddr_wr_len(ddr_wr_len),
    .ddr_wrdy(ddr_wrdy), .ddr_wdata_req(ddr_wdata_req), .ddr_wdone(ddr_wdone),
    .ddr_wdata(ddr_wdata), .grant_id(grant_id), .busy(busy),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_rr     = 0;
  bit m_ovr    = 1'b0;
  bit m_tmo    = 1'b0;
  int burst_no = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // First requesting, enabled channel at or after the round-robin pointer.
  function automatic int model_pick(input logic [CH-1:0] req, input logic [CH-1:0] en);
    for (int k = 0; k < CH; k++)
      if (req[(m_rr + k) % CH] && en[(m_rr + k) % CH]) return (m_rr + k) % CH;
    return 0;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wreq"}, ddr_wreq, 0);
    chk({tag, "_waddr"}, ddr_waddr, 0);
    chk({tag, "_len"}, ddr_wr_len, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant_id, 0);
    chk({tag, "_ovr"}, err_overrun, 0);
    chk({tag, "_tmo"}, err_timeout, 0);
    chk({tag, "_strobes"}, {ch_wrdy, ch_wdata_req, ch_wdone}, 0);
  endtask

  task automatic do_reset();
    ddr_wrdy = 0; ddr_wdata_req = 0; ddr_wdone = 0;
    rst = 1'b1;
    step();
    check_reset_vals("rst");
    step();
    rst = 1'b0;
    m_rr = 0; m_ovr = 0; m_tmo = 0;
  endtask

  task automatic grant_phase(output int g);
    int waits;
    g = model_pick(ch_wreq, ch_en);
    chk("idle_wreq", ddr_wreq, 0);
    step();
    chk("grant_id", grant_id, g);
    chk("wreq_latency", ddr_wreq, 1);
    chk("waddr", ddr_waddr, addr[g]);
    chk("wr_len", ddr_wr_len, len[g]);
    chk("busy_req", busy, 1);
    waits = $urandom_range(0, 2);
    for (int w = 0; w < waits; w++) begin
      ddr_wdata_req = 1'($urandom_range(0, 1));
      ddr_wdone     = 1'($urandom_range(0, 1));
      #1;
      chk("req_gating", {ch_wrdy, ch_wdata_req, ch_wdone}, 0);
      step();
      chk("req_hold", ddr_wreq, 1);
    end
    ddr_wdata_req = 0; ddr_wdone = 0; ddr_wrdy = 1;
    #1;
    chk("ch_wrdy", ch_wrdy, 4'b1 << g);
    step();
    ddr_wrdy = 0;
    chk("wreq_drop", ddr_wreq, 0);
    chk("busy_data", busy, 1);
  endtask

  task automatic data_phase(input int g, input int nbeats, input bit done_last, input bit drop_en);
    logic [CH-1:0] en_save;
    en_save = ch_en;
    if (drop_en) ch_en = '0;
    for (int b = 0; b < nbeats; b++) begin
      if (nbeats <= 16 && $urandom_range(0, 3) == 0) begin
        step();
        chk("gap_busy", busy, 1);
      end
      for (int c = 0; c < CH; c++) data[c] = {$urandom, $urandom, $urandom, $urandom};
      ddr_wdata_req = 1;
      ddr_wdone     = done_last && (b == nbeats - 1);
      #1;
      chk("beat_route", ch_wdata_req, 4'b1 << g);
      chk("wdata", ddr_wdata, data[g]);
      chk("done_route", ch_wdone, ddr_wdone ? (4'b1 << g) : 4'b0);
      if (b >= int'(len[g])) m_ovr = 1'b1;
      step();
      ddr_wdata_req = 0; ddr_wdone = 0;
      chk("overrun", err_overrun, m_ovr);
    end
    if (!done_last) begin
      ddr_wdone = 1;
      #1;
      chk("done_route_late", ch_wdone, 4'b1 << g);
      step();
      ddr_wdone = 0;
    end
    m_rr = (g + 1) % CH;
    chk("idle_gap_wreq", ddr_wreq, 0);
    chk("idle_busy", busy, 0);
    chk("timeout_flag", err_timeout, m_tmo);
    ch_en = en_save;
    burst_no++;
    $display("burst %0d: ch=%0d beats=%0d len=%0d addr=%h overrun=%0b timeout=%0b",
             burst_no, g, nbeats, len[g], addr[g], err_overrun, err_timeout);
  endtask

  task automatic run_burst(input int nbeats, input bit done_last, input bit drop_en);
    int g;
    grant_phase(g);
    data_phase(g, nbeats, done_last, drop_en);
  endtask

  task automatic randomize_channels(input int min_len);
    for (int c = 0; c < CH; c++) begin
      addr[c] = AW'($urandom);
      len[c]  = LW'($urandom_range(min_len, min_len + 30));
      data[c] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  initial begin
    int g;
    rst = 1'b1; ch_en = '0; ch_wreq = '0;
    ddr_wrdy = 0; ddr_wdata_req = 0; ddr_wdone = 0;
    for (int c = 0; c < CH; c++) begin addr[c] = '0; len[c] = '0; data[c] = '0; end
    @(negedge clk);
    do_reset();

    // Single channel, 160-beat burst
    ch_en = 4'b1111; ch_wreq = 4'b0001;
    addr[0] = 27'h0001000; len[0] = 16'd160;
    run_burst(160, 1'b1, 1'b0);
    ch_wreq = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_req_idle", ddr_wreq, 0);
    end

    // All four requesting continuously from rr_ptr=0
    do_reset();
    ch_wreq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      randomize_channels(8);
      run_burst($urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Channel 2 disabled; one burst drops every enable mid-flight
    do_reset();
    ch_en = 4'b1011; ch_wreq = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      randomize_channels(8);
      run_burst($urandom_range(1, 8), 1'b1, i == 1);
    end

    // Overrun: 5 beats against len=4, then stickiness
    do_reset();
    ch_en = 4'b1111; ch_wreq = 4'b0001;
    randomize_channels(8);
    len[0] = 16'd4;
    run_burst(5, 1'b1, 1'b0);
    len[0] = 16'd8;
    run_burst(3, 1'b0, 1'b0);

    // Watchdog: no ddr_wdone on channel 0, channel 1 must follow
    do_reset();
    ch_wreq = 4'b0011;
    randomize_channels(8);
    grant_phase(g);
    for (int k = 1; k <= TO; k++) begin
      step();
      chk("tmo_flag", err_timeout, k == TO);
      chk("tmo_busy", busy, k < TO);
    end
    m_tmo = 1'b1;
    m_rr  = (g + 1) % CH;
    run_burst(4, 1'b1, 1'b0);

    // Reset during DATA of a len=0 burst on channel 2
    do_reset();
    ch_wreq = 4'b1111;
    randomize_channels(8);
    run_burst(2, 1'b1, 1'b0);
    run_burst(2, 1'b1, 1'b0);
    len[2] = 16'd0;
    grant_phase(g);
    chk("rst_pre_grant", g, 2);
    ddr_wdata_req = 1;
    step();
    ddr_wdata_req = 0;
    chk("len0_overrun", err_overrun, 1);
    rst = 1'b1;
    step();
    ddr_wdone = 1; ddr_wdata_req = 1;
    #1;
    check_reset_vals("midrst");
    ddr_wdone = 0; ddr_wdata_req = 0;
    step();
    rst = 1'b0;
    m_rr = 0; m_ovr = 0; m_tmo = 0;
    run_burst(3, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
